// File: rtl/input_quant_packer.sv
// rtl/input_quant_packer.sv - quantises raw feature beats to 2-bit codes and packs one frame per vector
module input_quant_packer #(
  parameter int                FEAT_W   = 16,
  parameter int                NUM_FEAT = 8,
  parameter logic [FEAT_W-1:0] THR0     = 16'h0400,
  parameter logic [FEAT_W-1:0] THR1     = 16'h1000,
  parameter logic [FEAT_W-1:0] THR2     = 16'h4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FEAT_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*NUM_FEAT-1:0] m_data,
  output logic                  m_err
);

  localparam int                IDX_W    = $clog2(NUM_FEAT) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [2*NUM_FEAT-1:0] slots;
  logic                  err;
  logic                  sent;
  logic [1:0]            code;

  // Thresholds are ordered, so the last satisfied compare equals the count of thresholds <= s_data.
  always_comb begin
    code = 2'b00;
    if (s_data >= THR0) code = 2'b01;
    if (s_data >= THR1) code = 2'b10;
    if (s_data >= THR2) code = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      slots <= '0;
      err   <= 1'b0;
      sent  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            for (int i = 0; i < NUM_FEAT; i++) begin
              if (idx == IDX_W'(i)) slots[2*i +: 2] <= code;
            end
            if (idx == LAST_IDX) begin
              state <= s_last ? HOLD : DRAIN;
              err   <= !s_last;
              sent  <= 1'b0;
            end else if (s_last) begin
              state <= HOLD;
              err   <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            slots <= '0;
            idx   <= '0;
            err   <= 1'b0;
            state <= FILL;
          end
        end
        DRAIN: begin
          // sent marks that the vector already left while the overlong frame is still being discarded.
          if (!sent && m_ready) begin
            slots <= '0;
            idx   <= '0;
            err   <= 1'b0;
            if (s_valid && s_last) state <= FILL;
            else                   sent  <= 1'b1;
          end else if (s_valid && s_last) begin
            state <= sent ? FILL : HOLD;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign s_ready = (state != HOLD);
  assign m_valid = (state == HOLD) || (state == DRAIN && !sent);
  assign m_data  = slots;
  assign m_err   = err;

endmodule

// File: tb/tb_input_quant_packer.sv
// tb/tb_input_quant_packer.sv - randomized and directed bench for input_quant_packer against a frame-level model
module tb_input_quant_packer;

  localparam int          NF = 8;
  localparam logic [15:0] T0 = 16'h0400;
  localparam logic [15:0] T1 = 16'h1000;
  localparam logic [15:0] T2 = 16'h4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_err;

  always #5 clk = ~clk;

  input_quant_packer #(.FEAT_W(16), .NUM_FEAT(NF), .THR0(T0), .THR1(T1), .THR2(T2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect codes of accepted beats, emit a vector when a frame closes.
  typedef struct {
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t        q[$];
  int          codes[$];
  bit          discarding = 0;
  bit          rnd = 0;
  int          xfers = 0;
  logic [15:0] last_data = '0;
  logic        last_err = 1'b0;
  logic [15:0] model_last = '0;
  time         xfer_t[$];

  function automatic int code_of(input logic [15:0] d);
    int c = 0;
    if (d >= T0) c++;
    if (d >= T1) c++;
    if (d >= T2) c++;
    return c;
  endfunction

  always @(posedge rst) begin
    q.delete();
    codes.delete();
    discarding = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", {31'b0, m_valid}, {31'b0, q.size() != 0});
      chk("s_ready", {31'b0, s_ready}, {31'b0, !(q.size() != 0 && !discarding)});
      if (m_valid && q.size() != 0) begin
        chk("m_data", {16'b0, m_data}, {16'b0, q[0].data});
        chk("m_err", {31'b0, m_err}, {31'b0, q[0].err});
      end
      if (m_valid && m_ready) begin
        xfers++;
        last_data = m_data;
        last_err  = m_err;
        xfer_t.push_back($time);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (s_valid && s_ready) begin
        if (discarding) begin
          if (s_last) discarding = 0;
        end else begin
          codes.push_back(code_of(s_data));
          if (s_last || codes.size() == NF) begin
            vec_t v;
            v.data = '0;
            foreach (codes[i]) v.data = v.data | (16'(codes[i]) << (2 * i));
            v.err = !(s_last && codes.size() == NF);
            discarding = !s_last;
            q.push_back(v);
            model_last = v.data;
            codes.delete();
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int k);
    s_valid = 1'b0;
    repeat (k) step();
  endtask

  task automatic beat(input logic [15:0] d, input bit l);
    int n = 0;
    bit acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      acc = s_ready;
      step();
      if (acc) break;
      n++;
      if (n >= 200) begin
        chk("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic take();
    int n = 0;
    bit acc;
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc = m_valid;
      step();
      if (acc) break;
      n++;
      if (n >= 200) begin
        chk("take_timeout", 32'd0, 32'd1);
        break;
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_err", {31'b0, m_err}, 32'd0);
    chk("rst_m_data", {16'b0, m_data}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] tbl [8];
    tbl[0] = T0 - 16'd1; tbl[1] = T0; tbl[2] = T1 - 16'd1; tbl[3] = T1;
    tbl[4] = T2 - 16'd1; tbl[5] = T2; tbl[6] = 16'h0000;  tbl[7] = 16'hFFFF;
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  logic [15:0] pat [8];
  logic [15:0] held;
  int          x0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    pat[0] = 16'h0000; pat[1] = 16'h0400; pat[2] = 16'h1000; pat[3] = 16'h4000;
    pat[4] = 16'hFFFF; pat[5] = 16'h03FF; pat[6] = 16'h0FFF; pat[7] = 16'h3FFF;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_s_ready", {31'b0, s_ready}, 32'd1);
    chk("reset_m_valid", {31'b0, m_valid}, 32'd0);
    chk("reset_m_err", {31'b0, m_err}, 32'd0);
    step();

    // Mixed-code full frame.
    for (int i = 0; i < NF; i++) beat(pat[i], i == NF - 1);
    @(negedge clk);
    chk("full_m_data", {16'b0, m_data}, 32'b10_01_00_11_11_10_01_00);
    chk("full_model", {16'b0, model_last}, 32'b10_01_00_11_11_10_01_00);
    step();
    take();
    chk("full_xfer_data", {16'b0, last_data}, 32'b10_01_00_11_11_10_01_00);
    chk("full_xfer_err", {31'b0, last_err}, 32'd0);

    // Short frame.
    for (int i = 0; i < 3; i++) beat(16'h5000, i == 2);
    take();
    chk("short_data", {16'b0, last_data}, 32'h003F);
    chk("short_err", {31'b0, last_err}, 32'd1);
    chk("short_model", {16'b0, model_last}, 32'h003F);

    // Long frame with m_ready held high, then a clean frame.
    m_ready = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 10; i++) beat(16'h1000, i == 9);
    idle(2);
    chk("long_count", 32'(xfers - x0), 32'd1);
    chk("long_data", {16'b0, last_data}, 32'hAAAA);
    chk("long_err", {31'b0, last_err}, 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) beat(pat[i], i == NF - 1);
    take();
    chk("after_long_data", {16'b0, last_data}, 32'b10_01_00_11_11_10_01_00);
    chk("after_long_err", {31'b0, last_err}, 32'd0);

    // Backpressure: vector held for 5 cycles.
    for (int i = 0; i < NF; i++) beat(pick(), i == NF - 1);
    held = m_data;
    x0 = xfers;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_ready", {31'b0, s_ready}, 32'd0);
      chk("bp_m_valid", {31'b0, m_valid}, 32'd1);
      chk("bp_stable", {16'b0, m_data}, {16'b0, held});
      step();
    end
    take();
    chk("bp_count", 32'(xfers - x0), 32'd1);

    // Async reset mid-frame, then no stale codes.
    for (int i = 0; i < 4; i++) beat(16'hFFFF, 1'b0);
    x0 = xfers;
    do_reset();
    idle(2);
    chk("rst_no_xfer", 32'(xfers - x0), 32'd0);
    for (int i = 0; i < 3; i++) beat(16'h0000, i == 2);
    take();
    chk("rst_short_data", {16'b0, last_data}, 32'h0000);
    chk("rst_short_err", {31'b0, last_err}, 32'd1);
    for (int i = 0; i < NF; i++) beat(pat[i], i == NF - 1);
    take();
    chk("rst_full_data", {16'b0, last_data}, 32'b10_01_00_11_11_10_01_00);

    // Back-to-back throughput.
    m_ready = 1'b1;
    xfer_t.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NF; i++) beat(pick(), i == NF - 1);
    idle(2);
    chk("tp_count", 32'(xfer_t.size()), 32'd3);
    if (xfer_t.size() >= 3) begin
      chk("tp_gap0", 32'(xfer_t[1] - xfer_t[0]), 32'd90);
      chk("tp_gap1", 32'(xfer_t[2] - xfer_t[1]), 32'd90);
    end
    m_ready = 1'b0;

    // Randomized frames of length 1..11 with random gaps, backpressure and resets.
    rnd = 1;
    for (int f = 0; f < 250; f++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 150) == 0) do_reset();
        beat(pick(), k == len - 1);
      end
    end
    rnd = 0;
    m_ready = 1'b1;
    idle(4);
    chk("final_drain", 32'(q.size()), 32'd0);
    m_ready = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/input_quant_packer.md
INPUT_QUANT_PACKER -- requirements
Module: input_quant_packer

Interface
REQ-001 Parameter FEAT_W, default 16, width of one raw unsigned feature word.
REQ-002 Parameter NUM_FEAT, default 8, features per frame (range 2..64).
REQ-003 Parameter THR0/THR1/THR2, defaults 16'h0400/16'h1000/16'h4000, unsigned quantisation thresholds, THR0<=THR1<=THR2.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_valid  input  1  raw feature beat valid.
REQ-007 s_ready  output  1  block accepts beat this cycle.
REQ-008 s_data  input  FEAT_W  raw feature value.
REQ-009 s_last  input  1  beat is final feature of frame.
REQ-010 m_valid  output  1  packed activation vector valid.
REQ-011 m_ready  input  1  downstream layer-0 consumer accepts vector.
REQ-012 m_data  output  2*NUM_FEAT  packed 2-bit codes, feature i at bits [2i+1:2i].
REQ-013 m_err  output  1  frame-length error flag, qualified by m_valid.

Function
REQ-014 Beat transfer SHALL occur when s_valid&&s_ready; vector transfer when m_valid&&m_ready.
REQ-015 Code per beat SHALL be the unsigned count of thresholds <= s_data: <THR0 ->00, <THR1 ->01, <THR2 ->10, else 11.
REQ-016 States SHALL be FILL, HOLD, DRAIN; reset state FILL.
REQ-017 FILL: s_ready=1; each accepted beat writes its code to slot idx, idx increments (width clog2(NUM_FEAT)+1).
REQ-018 FILL, accepted beat with s_last and idx<NUM_FEAT-1: unwritten slots SHALL be 00, m_err=1 (short frame), go HOLD.
REQ-019 FILL, accepted beat at idx=NUM_FEAT-1 with s_last: m_err=0, go HOLD.
REQ-020 FILL, accepted beat at idx=NUM_FEAT-1 without s_last: m_err=1 (long frame), go DRAIN.
REQ-021 DRAIN: s_ready=1, m_valid=1, beats discarded until accepted beat with s_last; vector SHALL stay stable.
REQ-022 DRAIN exit: vector transferred and s_last beat accepted same cycle -> FILL; vector transferred first -> remain discarding with m_valid=0 until s_last, then FILL; s_last first -> HOLD.
REQ-023 HOLD: s_ready=0, m_valid=1; m_data/m_err SHALL not change while m_valid&&!m_ready.
REQ-024 HOLD with m_ready: vector transfers, slots cleared to 0, idx=0, m_err cleared, go FILL next cycle.
REQ-025 Latency: m_valid SHALL assert cycle after the closing beat is accepted; max throughput one frame per NUM_FEAT+1 cycles.
REQ-026 s_ready SHALL not depend combinationally on m_ready; m_valid SHALL not depend combinationally on s_valid.
REQ-027 Threshold compares SHALL be FEAT_W-bit unsigned; no sign extension.

Reset
REQ-028 On rst assertion, immediately and regardless of clk: state FILL, idx 0, all slots 00, m_valid 0, m_err 0, s_ready 1 after release.
REQ-029 rst mid-frame or mid-HOLD SHALL discard partial/pending vector; no transfer after release until a new frame completes.

Verification
REQ-030 NUM_FEAT=8, beats 0x0000,0x0400,0x1000,0x4000,0xFFFF,0x03FF,0x0FFF,0x3FFF(last) -> m_data 16'b10_01_00_11_11_10_01_00, m_err 0.
REQ-031 Three beats 0x5000 with s_last on third -> m_data 16'h003F, m_err 1.
REQ-032 Ten beats of 0x1000, s_last on tenth, m_ready=1 -> one vector 16'hAAAA, m_err 1, beats 9-10 discarded, next frame packs cleanly.
REQ-033 Full frame, m_ready held 0 for 5 cycles -> m_data stable, s_ready 0 throughout, single transfer when m_ready rises.
REQ-034 rst pulsed asynchronously after 4 beats -> outputs reset before next clk edge; following 8-beat frame yields correct vector, no stale codes.
REQ-035 Back-to-back frames with s_valid and m_ready always 1 -> one vector per 9 cycles, no beat lost or duplicated.
